// File: rtl/cmp_rx_pkg.sv
// Shared constants and types for the comparator-fiber RX frame path.
package cmp_rx_pkg;

  localparam logic [7:0] K_BYTE_LT_DEFAULT = 8'hFC;
  localparam logic [7:0] K_BYTE_SYNC       = 8'hBC;
  localparam logic [1:0] ISK_SYNC          = 2'b01;
  localparam int         FRAME_LEN         = 4;
  localparam int         WORD_W            = 16;

  // Assembled frame, last data word in the MSBs.
  typedef struct packed {
    logic [WORD_W-1:0] w3;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w1;
  } frame_t;

  function automatic logic is_sync(input logic [1:0] isk);
    return isk == ISK_SYNC;
  endfunction

endpackage

// File: rtl/cmp_rx_sync_monitor.sv
// K-word periodicity monitor: flags sync loss and keeps a saturating error count.
module cmp_rx_sync_monitor
  import cmp_rx_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CMP_RX_CLK160,
  input  logic                 CMP_RX_RESETDONE,
  input  logic                 sync_match,
  output logic                 syncword,
  output logic                 synclost,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [FRAME_LEN+1:1] pipe;
  logic [2:0]           cnt;
  logic                 sat;

  // cnt tracks K words in flight across one frame window; exactly one is healthy.
  always_ff @(posedge CMP_RX_CLK160 or negedge CMP_RX_RESETDONE) begin
    if (!CMP_RX_RESETDONE) begin
      syncword  <= 1'b0;
      pipe      <= '0;
      cnt       <= '0;
      synclost  <= 1'b0;
      err_count <= '0;
      sat       <= 1'b0;
    end else begin
      syncword <= sync_match;
      pipe     <= {pipe[FRAME_LEN:1], syncword};
      if (syncword && !pipe[FRAME_LEN])
        cnt <= cnt + 3'd1;
      else if (!syncword && pipe[FRAME_LEN])
        cnt <= cnt - 3'd1;
      synclost <= (pipe[FRAME_LEN] ^ syncword) | (cnt != 3'd1);
      if (!sat && pipe[FRAME_LEN+1] && synclost)
        err_count <= err_count + ERR_CNT_W'(1);
      // Registered one count early so the increment into all-ones is the last.
      sat <= &err_count[ERR_CNT_W-1:1];
    end
  end

endmodule

// File: rtl/cmp_rx_frame_assembler.sv
// GTX RX fabric side: comma-align control, phase-sync reset, 4-word frame assembly.
// Latency-trigger decode is built only with CMP_RX_LTNCY_TRIG_EN defined.
module cmp_rx_frame_assembler
  import cmp_rx_pkg::*;
#(
  parameter int ERR_CNT_W = 8
`ifdef CMP_RX_LTNCY_TRIG_EN
  , parameter logic [7:0] K_BYTE_LT = K_BYTE_LT_DEFAULT
`endif
) (
  input  logic                  CMP_RX_CLK160,
  input  logic                  CMP_RX_RESETDONE,
  input  logic [WORD_W-1:0]     RX_DATA,
  input  logic [1:0]            RX_ISK,
  input  logic                  RX_BYTE_IS_ALIGNED,
  output logic                  RX_CALIGN,
  output logic                  RX_SYNC_RST,
  output logic                  CEW0,
  output logic                  CEW1,
  output logic                  CEW2,
  output logic                  CEW3,
  output logic [3*WORD_W-1:0]   RCV_DATA,
  output logic [2:0]            NONZERO_WORD,
  output logic                  LTNCY_TRIG,
  output logic                  SYNCWORD,
  output logic                  SYNCLOST,
  output logic [ERR_CNT_W-1:0]  SYNC_ERR_COUNT
);

  logic                 sync_match;
  logic                 r1, r2, calign;
  logic [FRAME_LEN:1]   cew_pipe;
  logic [WORD_W-1:0]    w1, w2;
  frame_t               rcv_q;
  logic [2:0]           nz;

  assign sync_match = is_sync(RX_ISK);

  // cew_pipe[n] marks data word n of the frame; the last stage is CEW0.
  always_ff @(posedge CMP_RX_CLK160 or negedge CMP_RX_RESETDONE) begin
    if (!CMP_RX_RESETDONE) begin
      r1       <= 1'b0;
      r2       <= 1'b0;
      calign   <= 1'b1;
      cew_pipe <= '0;
      w1       <= '0;
      w2       <= '0;
      rcv_q    <= '0;
      nz       <= '0;
    end else begin
      r1       <= 1'b1;
      r2       <= r1;
      calign   <= ~RX_BYTE_IS_ALIGNED;
      cew_pipe <= {cew_pipe[FRAME_LEN-1:1], sync_match};
      if (cew_pipe[1]) begin
        w1    <= RX_DATA;
        nz[0] <= |RX_DATA;
      end
      if (cew_pipe[2]) begin
        w2    <= RX_DATA;
        nz[1] <= |RX_DATA;
      end
      if (cew_pipe[3]) begin
        rcv_q <= {RX_DATA, w2, w1};
        nz[2] <= |RX_DATA;
      end
    end
  end

  assign RX_SYNC_RST  = ~r2;
  assign RX_CALIGN    = calign;
  assign CEW1         = cew_pipe[1];
  assign CEW2         = cew_pipe[2];
  assign CEW3         = cew_pipe[3];
  assign CEW0         = cew_pipe[FRAME_LEN];
  assign RCV_DATA     = rcv_q;
  assign NONZERO_WORD = nz;

`ifdef CMP_RX_LTNCY_TRIG_EN
  logic lt, lt_reg, ltncy_q;

  // Sampled at CEW0, i.e. the K word that opens the next frame in a period-4 stream.
  assign lt = sync_match && (RX_DATA[7:0] == K_BYTE_LT);

  always_ff @(posedge CMP_RX_CLK160 or negedge CMP_RX_RESETDONE) begin
    if (!CMP_RX_RESETDONE) begin
      lt_reg  <= 1'b0;
      ltncy_q <= 1'b0;
    end else begin
      if (cew_pipe[FRAME_LEN]) lt_reg <= lt;
      if (cew_pipe[3])         ltncy_q <= lt_reg;
    end
  end

  assign LTNCY_TRIG = ltncy_q;
`else
  assign LTNCY_TRIG = 1'b0;
`endif

  cmp_rx_sync_monitor #(.ERR_CNT_W(ERR_CNT_W)) u_sync_mon (
    .CMP_RX_CLK160    (CMP_RX_CLK160),
    .CMP_RX_RESETDONE (CMP_RX_RESETDONE),
    .sync_match       (sync_match),
    .syncword         (SYNCWORD),
    .synclost         (SYNCLOST),
    .err_count        (SYNC_ERR_COUNT)
  );

endmodule

// File: tb/tb_cmp_rx_frame_assembler.sv
// Directed bench for cmp_rx_frame_assembler with a frame scoreboard.
module tb_cmp_rx_frame_assembler;
  import cmp_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] RX_DATA = '0;
  logic [1:0]  RX_ISK = '0;
  logic        RX_BYTE_IS_ALIGNED = 1'b0;
  logic        RX_CALIGN, RX_SYNC_RST, CEW0, CEW1, CEW2, CEW3;
  logic [47:0] RCV_DATA;
  logic [2:0]  NONZERO_WORD;
  logic        LTNCY_TRIG, SYNCWORD, SYNCLOST;
  logic [7:0]  SYNC_ERR_COUNT;

  cmp_rx_frame_assembler dut (
    .CMP_RX_CLK160      (clk),
    .CMP_RX_RESETDONE   (rst_n),
    .RX_DATA            (RX_DATA),
    .RX_ISK             (RX_ISK),
    .RX_BYTE_IS_ALIGNED (RX_BYTE_IS_ALIGNED),
    .RX_CALIGN          (RX_CALIGN),
    .RX_SYNC_RST        (RX_SYNC_RST),
    .CEW0               (CEW0),
    .CEW1               (CEW1),
    .CEW2               (CEW2),
    .CEW3               (CEW3),
    .RCV_DATA           (RCV_DATA),
    .NONZERO_WORD       (NONZERO_WORD),
    .LTNCY_TRIG         (LTNCY_TRIG),
    .SYNCWORD           (SYNCWORD),
    .SYNCLOST           (SYNCLOST),
    .SYNC_ERR_COUNT     (SYNC_ERR_COUNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] data;
    logic [2:0]  nz;
    logic        lt;
  } exp_t;

  exp_t        sb_q[$];
  logic [17:0] wlog[$];   // {isk, data} per cycle since reset release
  int          n_chk = 0, n_pass = 0, n_push = 0, n_pop = 0;
  logic        sb_en = 1'b0;
  logic        sl_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] isk, input logic [15:0] data);
    @(posedge clk); #1;
    RX_ISK  = isk;
    RX_DATA = data;
    wlog.push_back({isk, data});
  endtask

  // Trigger flag of the frame starting at cycle t: the value latched at the last
  // CEW0 (4 cycles after an earlier K word) up to t, cleared by reset.
  function automatic logic exp_lt(input int t);
`ifdef CMP_RX_LTNCY_TRIG_EN
    for (int c = t; c >= 4; c--)
      if (wlog[c-4][17:16] == 2'b01)
        return (wlog[c][17:16] == 2'b01) && (wlog[c][7:0] == 8'hFC);
    return 1'b0;
`else
    return (t < 0);
`endif
  endfunction

  task automatic send_frame(input logic [7:0] k, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] c);
    exp_t e;
    int   t;
    t = wlog.size();
    drive(2'b01, {8'h50, k});
    e.data = {c, b, a};
    e.nz   = {|c, |b, |a};
    e.lt   = exp_lt(t);
    sb_q.push_back(e);
    n_push++;
    drive(2'b00, a);
    drive(2'b00, b);
    drive(2'b00, c);
  endtask

  always @(negedge clk) begin
    if (sb_en && CEW0) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_pop++;
        chk("rcv_data", RCV_DATA, e.data);
        chk("nonzero_word", NONZERO_WORD, e.nz);
        chk("ltncy_trig", LTNCY_TRIG, e.lt);
      end
    end
    if (SYNCLOST) sl_seen = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rcv_data", RCV_DATA, 48'h0);
    chk("rst_cew", {CEW0, CEW1, CEW2, CEW3}, 4'b0000);
    chk("rst_calign", RX_CALIGN, 1'b1);
    chk("rst_sync_rst", RX_SYNC_RST, 1'b1);
    chk("rst_err_cnt", SYNC_ERR_COUNT, 8'h00);
    chk("rst_synclost", SYNCLOST, 1'b0);

    // Release: sync reset drops on the 2nd edge, comma align follows byte alignment
    @(posedge clk); #1;
    rst_n = 1'b1;
    wlog.delete();
    drive(2'b00, 16'h0);
    chk("sync_rst_edge1", RX_SYNC_RST, 1'b1);
    drive(2'b00, 16'h0);
    chk("sync_rst_edge2", RX_SYNC_RST, 1'b0);
    chk("calign_unaligned", RX_CALIGN, 1'b1);
    RX_BYTE_IS_ALIGNED = 1'b1;
    chk("calign_before_edge", RX_CALIGN, 1'b1);
    drive(2'b00, 16'h0);
    chk("calign_aligned", RX_CALIGN, 1'b0);
    repeat (4) drive(2'b00, 16'h0);

    // First frame: explicit strobe timing
    sb_en = 1'b1;
    drive(2'b01, 16'h50BC);
    sb_q.push_back('{data: 48'h9ABC_5678_1234, nz: 3'b111, lt: 1'b0});
    n_push++;
    drive(2'b00, 16'h1234);
    chk("cew1_t1", {CEW0, CEW1, CEW2, CEW3}, 4'b0100);
    drive(2'b00, 16'h5678);
    chk("cew2_t2", {CEW0, CEW1, CEW2, CEW3}, 4'b0010);
    drive(2'b00, 16'h9ABC);
    chk("cew3_t3", {CEW0, CEW1, CEW2, CEW3}, 4'b0001);
    chk("rcv_not_yet", RCV_DATA, 48'h0);

    // Periodic stream
    send_frame(8'hBC, 16'h0000, 16'h00FF, 16'h0000);
    send_frame(8'hFC, 16'h1111, 16'h0000, 16'h2222);
    send_frame(8'hFC, 16'h0001, 16'h8000, 16'hFFFF);
    send_frame(8'hBC, 16'h1234, 16'h5678, 16'h9ABC);
    chk("steady_synclost", SYNCLOST, 1'b0);
    chk("steady_err_cnt", SYNC_ERR_COUNT, 8'h00);

    // One K word missing
    sl_seen = 1'b0;
    repeat (4) drive(2'b00, 16'h0);
    send_frame(8'hFC, 16'hA5A5, 16'h0000, 16'h0000);
    send_frame(8'hFC, 16'h0000, 16'h0000, 16'h0042);
    send_frame(8'hBC, 16'h1234, 16'h5678, 16'h9ABC);
    send_frame(8'hBC, 16'h0000, 16'h00FF, 16'h0000);
    chk("drop_synclost_pulse", sl_seen, 1'b1);
    chk("drop_err_cnt", SYNC_ERR_COUNT, 8'h01);
    chk("recovered_synclost", SYNCLOST, 1'b0);

    // Continuous errors: K every cycle
    for (int i = 0; i < 300; i++) begin
      drive(2'b01, 16'h50BC);
      if (i == 1) sb_en = 1'b0;
    end
    chk("sat_err_cnt", SYNC_ERR_COUNT, 8'hFF);
    chk("sat_synclost", SYNCLOST, 1'b1);
    repeat (20) drive(2'b01, 16'h50BC);
    chk("sat_hold", SYNC_ERR_COUNT, 8'hFF);

    // Reset mid-frame acts immediately
    drive(2'b00, 16'h7777);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rcv_data", RCV_DATA, 48'h0);
    chk("midrst_cew", {CEW0, CEW1, CEW2, CEW3}, 4'b0000);
    chk("midrst_err_cnt", SYNC_ERR_COUNT, 8'h00);
    chk("midrst_synclost", SYNCLOST, 1'b0);
    chk("midrst_nz_lt", {NONZERO_WORD, LTNCY_TRIG}, 4'b0000);
    chk("midrst_sync_rst", RX_SYNC_RST, 1'b1);
    chk("midrst_calign", RX_CALIGN, 1'b1);
    sb_q.delete();
    RX_ISK  = 2'b00;
    RX_DATA = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wlog.delete();
    repeat (6) drive(2'b00, 16'h0);
    chk("post_rst_no_partial", RCV_DATA, 48'h0);

    // Fresh stream after reset
    sb_en = 1'b1;
    send_frame(8'hFC, 16'h0101, 16'h0202, 16'h0303);
    send_frame(8'hFC, 16'h0000, 16'h0000, 16'h0000);
    repeat (6) drive(2'b00, 16'h0);
    chk("post_rst_hold", RCV_DATA, 48'h0);

    chk("sb_empty", sb_q.size(), 0);
    chk("frames_popped", n_pop, n_push);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
